// File: rtl/mem_stall_pkg.sv
// Shared types and widths for the MEM-stage memory stall controller.
package mem_stall_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/mem_stall_if.sv
// Bundle of MEM-stage request signals and data-memory handshake signals.
// The master side is the stall controller; the slave side is the pipeline and memory.
interface mem_stall_if
    import mem_stall_pkg::*;
#(
    parameter int unsigned CNT_W = 16
);

    logic              MEM_memRead_in;
    logic              MEM_memWrite_in;
    logic [ADDR_W-1:0] MEM_addr_in;
    logic [DATA_W-1:0] MEM_wdata_in;
    logic              mem_busy;
    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_stall;
    logic [DATA_W-1:0] rd_data;
    logic              err;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        input  MEM_memRead_in, MEM_memWrite_in, MEM_addr_in, MEM_wdata_in,
        input  mem_busy, mem_done, mem_rdata,
        output mem_en, mem_wr, mem_addr, mem_wdata, mem_stall,
        output rd_data, err, stall_cnt
    );

    modport slave (
        output MEM_memRead_in, MEM_memWrite_in, MEM_addr_in, MEM_wdata_in,
        output mem_busy, mem_done, mem_rdata,
        input  mem_en, mem_wr, mem_addr, mem_wdata, mem_stall,
        input  rd_data, err, stall_cnt
    );

endinterface

// File: rtl/mem_stall_wdog.sv
// WAIT-state watchdog: counts cycles while enabled and flags the TIMEOUT-th one.
// Only instantiated when MEM_STALL_TIMEOUT_EN is defined.
module mem_stall_wdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    // High during the last permitted WAIT cycle so the FSM leaves on that edge.
    assign expire = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stall_ctrl.sv
// MEM-stage data-memory access controller: runs the ready/done handshake and stalls the pipeline.
// Optional WAIT watchdog compiled in with MEM_STALL_TIMEOUT_EN.
module mem_stall_ctrl
    import mem_stall_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic         clk,
    input  logic         rst,
    mem_stall_if.master  bus
);

    state_t            state;
    logic              req;
    logic              bad_req;
    logic              stall;
    logic              wdog_expire;
    logic              en_q;
    logic              wr_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    assign req     = bus.MEM_memRead_in | bus.MEM_memWrite_in;
    assign bad_req = bus.MEM_addr_in[0] | (bus.MEM_memRead_in & bus.MEM_memWrite_in);

    // Gated by reset so the pipeline is released the moment reset asserts.
    assign stall = rst & (((state == IDLE) & req) | (state == REQ) | (state == WAIT));

`ifdef MEM_STALL_TIMEOUT_EN
    mem_stall_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (state != WAIT),
        .en     (state == WAIT),
        .expire (wdog_expire)
    );
`else
    // Without the watchdog WAIT only ends on mem_done; TIMEOUT has no effect.
    assign wdog_expire = (TIMEOUT == 0) & 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            en_q        <= 1'b0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_data_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            en_q  <= 1'b0;
            err_q <= 1'b0;
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        if (bad_req) begin
                            state <= RESP;
                            err_q <= 1'b1;
                        end else begin
                            state   <= REQ;
                            en_q    <= 1'b1;
                            addr_q  <= bus.MEM_addr_in;
                            wdata_q <= bus.MEM_wdata_in;
                            wr_q    <= bus.MEM_memWrite_in;
                        end
                    end
                end
                REQ: begin
                    if (!bus.mem_busy) begin
                        state <= WAIT;
                    end else begin
                        en_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.mem_done) begin
                        if (!wr_q) begin
                            rd_data_q <= bus.mem_rdata;
                        end
                        state <= RESP;
                    end else if (wdog_expire) begin
                        state <= RESP;
                        err_q <= 1'b1;
                    end
                end
                // The request inputs still show the finished instruction here.
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en    = en_q;
    assign bus.mem_wr    = wr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_stall = stall;
    assign bus.rd_data   = rd_data_q;
    assign bus.err       = err_q;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Randomized self-checking bench for mem_stall_ctrl with a transaction-level memory model.
// The timeout case runs only when MEM_STALL_TIMEOUT_EN is defined.
module tb_mem_stall_ctrl;
    import mem_stall_pkg::*;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [15:0] exp_rd = 16'h0000;
    int          exp_cnt = 0;

    mem_stall_if #(.CNT_W(CNT_W)) bus ();

    mem_stall_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.MEM_memRead_in  = 1'b0;
            bus.MEM_memWrite_in = 1'b0;
            bus.mem_busy        = 1'b0;
            bus.mem_done        = 1'($urandom_range(0, 1));
            #1;
            checkOutput("idle_stall", bus.mem_stall, 0);
            checkOutput("idle_en", bus.mem_en, 0);
        end
    endtask

    // kind: 0 load, 1 store, 2 load+store. nb = busy cycles, nw = extra WAIT cycles.
    task automatic applyStimulus(input int kind, input logic [15:0] addr, input logic [15:0] wdata,
                                 input logic [15:0] rdata, input int nb, input int nw, input bit no_done);
        bit bad;
        bit finished;
        bit in_wait;
        int exp_stall;
        int exp_en;
        int stall_seen;
        int en_seen;
        int cycles;
        int busy_left;
        int wait_left;
        bad        = (kind == 2) || addr[0];
        exp_stall  = bad ? 1 : (no_done ? 2 + nb + int'(TIMEOUT) : 3 + nb + nw);
        exp_en     = bad ? 0 : nb + 1;
        finished   = 1'b0;
        in_wait    = 1'b0;
        stall_seen = 0;
        en_seen    = 0;
        cycles     = 0;
        busy_left  = nb;
        wait_left  = nw;
        @(negedge clk);
        bus.MEM_memRead_in  = (kind != 1);
        bus.MEM_memWrite_in = (kind != 0);
        bus.MEM_addr_in     = addr;
        bus.MEM_wdata_in    = wdata;
        bus.mem_busy        = 1'b0;
        bus.mem_done        = 1'($urandom_range(0, 1));
        bus.mem_rdata       = 16'($urandom);
        #1;
        while (!finished && cycles < 40) begin
            if (cycles > 0 && !bus.mem_stall) begin
                finished = 1'b1;
                if (kind == 0 && !bad && !no_done) exp_rd = rdata;
                exp_cnt = (exp_cnt + exp_stall > 65535) ? 65535 : exp_cnt + exp_stall;
                checkOutput("err_resp", bus.err, 32'(bad || no_done));
                checkOutput("rd_data", bus.rd_data, exp_rd);
                checkOutput("stall_cnt", bus.stall_cnt, exp_cnt);
                checkOutput("stall_cycles", stall_seen, exp_stall);
                checkOutput("en_cycles", en_seen, exp_en);
                bus.mem_done  = 1'($urandom_range(0, 1));
                bus.mem_rdata = 16'($urandom);
            end else begin
                stall_seen++;
                if (cycles > 0) checkOutput("err_busy", bus.err, 0);
                if (bus.mem_en) begin
                    en_seen++;
                    checkOutput("mem_addr", bus.mem_addr, addr);
                    checkOutput("mem_wdata", bus.mem_wdata, wdata);
                    checkOutput("mem_wr", bus.mem_wr, 32'(kind == 1));
                    bus.mem_done  = 1'($urandom_range(0, 1));
                    bus.mem_rdata = 16'($urandom);
                    if (busy_left > 0) begin
                        bus.mem_busy = 1'b1;
                        busy_left--;
                    end else begin
                        bus.mem_busy = 1'b0;
                        in_wait      = 1'b1;
                    end
                end else if (in_wait) begin
                    bus.mem_busy = 1'($urandom_range(0, 1));
                    if (!no_done && wait_left == 0) begin
                        bus.mem_done  = 1'b1;
                        bus.mem_rdata = rdata;
                    end else begin
                        bus.mem_done  = 1'b0;
                        bus.mem_rdata = 16'($urandom);
                        if (wait_left > 0) wait_left--;
                    end
                end
            end
            cycles++;
            if (!finished) begin
                @(negedge clk);
                #1;
            end
        end
        if (!finished) checkOutput("resp_reached", 0, 1);
    endtask

    task automatic resetInWait();
        @(negedge clk);
        bus.MEM_memRead_in  = 1'b1;
        bus.MEM_memWrite_in = 1'b0;
        bus.MEM_addr_in     = 16'h0106;
        bus.MEM_wdata_in    = 16'h5A5A;
        bus.mem_busy        = 1'b0;
        bus.mem_done        = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_en", bus.mem_en, 0);
        checkOutput("rst_wr", bus.mem_wr, 0);
        checkOutput("rst_stall", bus.mem_stall, 0);
        checkOutput("rst_err", bus.err, 0);
        checkOutput("rst_addr", bus.mem_addr, 0);
        checkOutput("rst_wdata", bus.mem_wdata, 0);
        checkOutput("rst_rd_data", bus.rd_data, 0);
        checkOutput("rst_stall_cnt", bus.stall_cnt, 0);
        @(negedge clk);
        bus.MEM_memRead_in = 1'b0;
        bus.mem_done       = 1'b1;
        bus.mem_rdata      = 16'hCAFE;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.mem_done = 1'b0;
        #1;
        checkOutput("post_rst_stall", bus.mem_stall, 0);
        checkOutput("post_rst_en", bus.mem_en, 0);
        checkOutput("post_rst_rd_data", bus.rd_data, 0);
        checkOutput("post_rst_err", bus.err, 0);
        checkOutput("post_rst_cnt", bus.stall_cnt, 0);
        exp_rd  = 16'h0000;
        exp_cnt = 0;
    endtask

    initial begin
        int sel;
        int kind;
        logic [15:0] addr;
        bus.MEM_memRead_in  = 1'b0;
        bus.MEM_memWrite_in = 1'b0;
        bus.MEM_addr_in     = 16'h0000;
        bus.MEM_wdata_in    = 16'h0000;
        bus.mem_busy        = 1'b0;
        bus.mem_done        = 1'b0;
        bus.mem_rdata       = 16'h0000;
        #12;
        checkOutput("reset_stall", bus.mem_stall, 0);
        checkOutput("reset_en", bus.mem_en, 0);
        checkOutput("reset_err", bus.err, 0);
        checkOutput("reset_rd_data", bus.rd_data, 0);
        checkOutput("reset_stall_cnt", bus.stall_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        idleCycles(2);

        applyStimulus(0, 16'h0040, 16'h0000, 16'hBEEF, 0, 1, 1'b0);
        idleCycles(1);
        applyStimulus(1, 16'h0010, 16'h1234, 16'h0000, 3, 0, 1'b0);
        idleCycles(1);
        applyStimulus(0, 16'h0041, 16'h0000, 16'h1111, 0, 0, 1'b0);
        idleCycles(1);
        applyStimulus(2, 16'h0020, 16'h7777, 16'h2222, 0, 0, 1'b0);
        applyStimulus(0, 16'h0002, 16'h0000, 16'hA001, 0, 0, 1'b0);
        applyStimulus(0, 16'h0004, 16'h0000, 16'hA002, 1, 2, 1'b0);
        idleCycles(1);

        for (int t = 0; t < 40; t++) begin
            sel  = $urandom_range(0, 7);
            kind = (sel < 4) ? 0 : ((sel < 7) ? 1 : 2);
            addr = 16'($urandom);
            if ($urandom_range(0, 5) != 0) addr[0] = 1'b0;
            applyStimulus(kind, addr, 16'($urandom), 16'($urandom),
                          $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
            idleCycles($urandom_range(0, 2));
        end

        resetInWait();
        applyStimulus(0, 16'h0080, 16'h0000, 16'h4321, 0, 0, 1'b0);
        idleCycles(1);

`ifdef MEM_STALL_TIMEOUT_EN
        applyStimulus(0, 16'h0200, 16'h0000, 16'hDEAD, 1, 0, 1'b1);
        idleCycles(1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_stall_ctrl.md
# mem_stall_ctrl

Multi-cycle data-memory access controller in the MEM stage of the 16-bit five-stage pipeline. It accepts load/store requests from the MEM stage and runs the ready/done handshake with the data memory/cache. Until the access completes it drives a pipeline-wide stall that freezes PC, IF/ID, ID/EX and EX/MEM, so it is the memory-side source of stalls rather than the decode-side hazard detector. It returns load data into MEM/WB on the single release cycle.

## Interface
Parameters:
- TIMEOUT, 255: maximum WAIT cycles before the access is aborted (only used with the watchdog compiled in).
- CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset, **asynchronous, active-low** (0 = reset).
- MEM_memRead_in  in  1  load request from EX/MEM.
- MEM_memWrite_in  in  1  store request from EX/MEM.
- MEM_addr_in  in  16  byte address.
- MEM_wdata_in  in  16  store data.
- mem_busy  in  1  memory cannot accept a request this cycle.
- mem_done  in  1  memory finished the outstanding access.
- mem_rdata  in  16  read data, valid with mem_done.
- mem_en  out  1  request strobe to memory.
- mem_wr  out  1  1 = write.
- mem_addr  out  16  registered address.
- mem_wdata  out  16  registered write data.
- mem_stall  out  1  freeze pipeline registers and PC.
- rd_data  out  16  load data to MEM/WB, held until the next load completes.
- err  out  1  one-cycle error pulse in RESP.
- stall_cnt  out  CNT_W  saturating count of cycles with mem_stall = 1.

## Operation
- The FSM has four states: IDLE, REQ, WAIT, RESP.
- A request is req = MEM_memRead_in | MEM_memWrite_in.
- IDLE, req = 1:
  - Latch addr, wdata and wr = MEM_memWrite_in, then go to REQ.
  - mem_stall is asserted combinationally in this same cycle.
- IDLE, misaligned request (req = 1 and MEM_addr_in[0] = 1):
  - No access is issued and the FSM goes directly to RESP with err = 1.
- IDLE, read and write both asserted:
  - Treat as an error, identical to a misaligned request.
- REQ:
  - mem_en = 1.
  - If mem_busy = 0, go to WAIT. Otherwise hold REQ and keep mem_en asserted.
- WAIT:
  - mem_en = 0.
  - On mem_done, capture mem_rdata into rd_data (loads only) and go to RESP.
- RESP:
  - mem_stall = 0, so the pipeline advances at this clock edge. Go to IDLE.
  - Request inputs are ignored in RESP because they still show the completed instruction.
- mem_stall = (IDLE & req) | REQ | WAIT.
- Stores do not change rd_data.
- mem_done outside WAIT is ignored.
- stall_cnt increments on every cycle with mem_stall = 1 and saturates at all-ones.
- Reset (asynchronous, any state, including mid-access):
  - FSM = IDLE; the outstanding access is abandoned.
  - mem_en, mem_wr, mem_stall, err = 0.
  - mem_addr, mem_wdata, rd_data = 16'h0000.
  - stall_cnt = 0.

## Timing
- Minimum access (mem_busy = 0, mem_done on the first WAIT cycle):
  - Request seen in cycle 0, REQ in cycle 1, WAIT in cycle 2, RESP in cycle 3.
  - mem_stall is high for cycles 0–2, which is 3 stall cycles.
- Each extra mem_busy cycle or extra WAIT cycle adds exactly one stall cycle.
- rd_data is valid from the RESP cycle onward.
- err pulses for exactly the RESP cycle.
- Back-to-back loads: the second request is seen in the IDLE cycle right after RESP, with no gap cycle required.
- All outputs are registered except mem_stall, which is combinational.

## Configuration
- MEM_STALL_TIMEOUT_EN defined:
  - A watchdog counts WAIT cycles.
  - On reaching TIMEOUT without mem_done: go to RESP with err = 1; rd_data is unchanged.
  - The count clears on entry to WAIT and on reset.
- MEM_STALL_TIMEOUT_EN undefined:
  - WAIT persists until mem_done. No watchdog logic is generated and TIMEOUT is unused.

## Structure
- Package mem_stall_pkg holds:
  - the state enum (IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3);
  - the 16-bit ADDR_W/DATA_W constants.
- Sub-module mem_stall_wdog: the TIMEOUT counter with clear/enable inputs and an expire output. It is instantiated only under MEM_STALL_TIMEOUT_EN.

## Test plan
- Load, addr 16'h0040, mem_busy = 0, mem_done 2 cycles after mem_en, mem_rdata = 16'hBEEF:
  - mem_stall high for 4 cycles; rd_data = 16'hBEEF in RESP; stall_cnt = 4.
- Store, addr 16'h0010, data 16'h1234, mem_busy high for 3 cycles:
  - mem_en held 4 cycles with mem_wr = 1, mem_addr = 16'h0010, mem_wdata = 16'h1234; rd_data unchanged.
- Misaligned load, addr 16'h0041:
  - No mem_en; mem_stall high for 1 cycle; err pulses in the next cycle.
- Back-to-back loads to 16'h0002 then 16'h0004:
  - Second request accepted in the cycle after the first RESP; two distinct rd_data values in order.
- Reset asserted low in WAIT:
  - All outputs go to their reset values immediately (before the next edge); a later mem_done is ignored; after release the FSM stays in IDLE.
- With MEM_STALL_TIMEOUT_EN and TIMEOUT = 8, mem_done never asserted:
  - RESP with err = 1 after 8 WAIT cycles; mem_stall drops.
